module_upsample_2x2: RTL and testbench
======================================

// Module: module_upsample_2x2
// PURPOSE
//  2x2 nearest-neighbour upsampler (un-pooling) for the CNN feature-map stream.
//  Each ROW_NUM x COL_NUM input frame becomes a (2*ROW_NUM) x (2*COL_NUM) output frame.
//  Each input pixel is repeated twice horizontally, and each expanded row is repeated twice.
//  The block is the inverse counterpart of the 2x2 max-pool stage and sits on decoder-side layers.
//  Output bandwidth is 4x input bandwidth, so both ports use valid/ready.
// PARAMETERS
//  WIDTH    8   pixel width; signed two's complement, passed through unmodified
//  COL_NUM  64  input pixels per row (>=2)
//  ROW_NUM  64  input rows per frame (>=1)
// PORTS
//  clk        in   1      single clock; all logic on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      din holds a valid input pixel
//  in_ready   out  1      block accepts din this cycle
//  din        in   WIDTH  signed input pixel, raster order
//  out_valid  out  1      dout holds a valid output pixel
//  out_ready  in   1      downstream accepts dout this cycle
//  dout       out  WIDTH  signed output pixel, raster order
//  out_last   out  1      high with the final output pixel of a frame
// BEHAVIOUR
//  - Transfer rules:
//    - Input beat when in_valid && in_ready.
//    - Output beat when out_valid && out_ready.
//    - dout and out_last stay stable while out_valid=1 and out_ready=0.
//  - Storage: row buffer buf[0:COL_NUM-1] of WIDTH bits. It is not cleared by reset.
//  - Counters:
//    - wr_col: 0..COL_NUM-1
//    - rd_idx: 0..2*COL_NUM-1
//    - row_cnt: 0..ROW_NUM-1
//  - FSM states: LOAD, EMIT_A, EMIT_B.
//  - LOAD:
//    - in_ready=1 and out_valid=0.
//    - Each input beat writes buf[wr_col] and increments wr_col.
//    - The beat with wr_col==COL_NUM-1 clears wr_col and moves to EMIT_A next cycle.
//    - Latency: out_valid rises in the cycle after that last input beat is accepted.
//  - EMIT_A / EMIT_B:
//    - in_ready=0 and out_valid=1.
//    - dout = buf[rd_idx>>1], so each pixel appears on two consecutive beats.
//    - rd_idx increments on each output beat.
//    - At rd_idx==2*COL_NUM-1, the beat clears rd_idx.
//    - From EMIT_A, that beat moves to EMIT_B.
//    - From EMIT_B, that beat moves to LOAD and updates row_cnt:
//      row_cnt becomes 0 if it was ROW_NUM-1, otherwise it increments by 1.
//  - No overlap: no input beats are accepted while emitting.
//    Sustained throughput is COL_NUM inputs per 5*COL_NUM cycles.
//  - out_last=1 only when all of these hold: state EMIT_B, rd_idx==2*COL_NUM-1,
//    row_cnt==ROW_NUM-1. Otherwise out_last=0.
//  - Stall: out_ready=0 freezes rd_idx, state and dout. There is no timeout.
//  - Reset values, asserted at any time including mid-row or mid-emit:
//    - State=LOAD, all counters=0.
//    - in_ready=1, out_valid=0, out_last=0.
//    - dout is don't-care while out_valid=0.
//    - Any partial row is discarded; the first beat after reset is treated as pixel (0,0).
//  - in_valid while in_ready=0 is ignored. The upstream must hold din until it is accepted.
// TESTING
//  1. COL_NUM=4, ROW_NUM=2, row0 = 1,2,3,4 with out_ready=1:
//     expect out 1,1,2,2,3,3,4,4 twice, out_valid rising 1 cycle after the 4th input beat,
//     and in_ready=0 for 16 cycles.
//  2. Full 2x4 frame with row1 = -1,-128,127,0:
//     expect 32 beats, out_last=1 only on beat 32 (value 0), and row_cnt wrapped to 0.
//  3. out_ready toggling 1,0,0,1 during EMIT_A:
//     expect dout/out_last constant during stalls, no beat lost or duplicated,
//     and the sequence identical to test 1.
//  4. in_valid gaps (1 of every 3 cycles) in LOAD:
//     expect the buffer to capture only valid beats and the output sequence unchanged.
//  5. rst pulsed after the 6th output beat of row0:
//     expect out_valid=0 and in_ready=1 immediately; next row 9,8,7,6 emits 9,9,8,8,7,7,6,6 twice.
//  6. in_valid held high with distinct values during EMIT states:
//     expect no acceptance (in_ready=0) and the buffer contents unchanged.

Source files
------------

// File: rtl/module_upsample_2x2_if.sv
// Stream bundle for the 2x2 upsampler.
//   in_valid/in_ready/din           : input pixel stream (raster order)
//   out_valid/out_ready/dout/out_last : output pixel stream, out_last marks frame end
// The slave modport is the upsampler's view. The master modport is the
// view of whatever sources pixels and sinks the expanded stream.
interface module_upsample_2x2_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             out_last;

   modport slave (
      input  in_valid, din, out_ready,
      output in_ready, out_valid, dout, out_last
   );

   modport master (
      output in_valid, din, out_ready,
      input  in_ready, out_valid, dout, out_last
   );
endinterface

// File: rtl/module_upsample_2x2.sv
// 2x2 nearest-neighbour upsampler (un-pooling).
// The block collects one input row into a row buffer (LOAD). It then emits
// that row twice (EMIT_A, EMIT_B), and every pixel is repeated on two
// consecutive output beats. Input and output phases never overlap.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : stream bundle (slave modport), valid/ready on both sides
module module_upsample_2x2 #(
   parameter int WIDTH   = 8,
   parameter int COL_NUM = 64,
   parameter int ROW_NUM = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   module_upsample_2x2_if.slave   bus
);
   localparam int CW  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
   localparam int RDW = CW + 1;
   localparam int RW  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

   localparam logic [CW-1:0]  COL_LAST = CW'(COL_NUM - 1);
   localparam logic [RDW-1:0] RD_LAST  = RDW'(2 * COL_NUM - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(ROW_NUM - 1);

   typedef enum logic [1:0] {LOAD, EMIT_A, EMIT_B} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    wr_col_q, wr_col_d;
   logic [RDW-1:0]   rd_idx_q, rd_idx_d;
   logic [RW-1:0]    row_cnt_q, row_cnt_d;
   logic [WIDTH-1:0] buf_q [COL_NUM];

   logic in_ready_o, out_valid_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         wr_col_q  <= '0;
         rd_idx_q  <= '0;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_col_q  <= wr_col_d;
         rd_idx_q  <= rd_idx_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   // The row buffer has no reset. A stale row can never be emitted, because
   // emission only starts after a full row has been written again.
   always_ff @(posedge clk) begin
      if (state_q == LOAD && bus.in_valid)
         buf_q[wr_col_q] <= bus.din;
   end

   always_comb begin
      state_d     = state_q;
      wr_col_d    = wr_col_q;
      rd_idx_d    = rd_idx_q;
      row_cnt_d   = row_cnt_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         LOAD: begin
            in_ready_o = 1'b1;
            if (bus.in_valid) begin
               if (wr_col_q == COL_LAST) begin
                  wr_col_d = '0;
                  state_d  = EMIT_A;
               end else begin
                  wr_col_d = wr_col_q + 1'b1;
               end
            end
         end
         EMIT_A, EMIT_B: begin
            out_valid_o = 1'b1;
            if (bus.out_ready) begin
               if (rd_idx_q == RD_LAST) begin
                  rd_idx_d = '0;
                  if (state_q == EMIT_A) begin
                     state_d = EMIT_B;
                  end else begin
                     state_d   = LOAD;
                     row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
                  end
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign bus.in_ready  = in_ready_o;
   assign bus.out_valid = out_valid_o;
   // Dropping the low bit of rd_idx repeats each pixel on two beats. The value
   // holds during a stall because rd_idx and the buffer are frozen while emitting.
   assign bus.dout      = buf_q[rd_idx_q[RDW-1:1]];
   assign bus.out_last  = (state_q == EMIT_B) && (rd_idx_q == RD_LAST) &&
                          (row_cnt_q == ROW_LAST);
endmodule

// File: tb/tb_module_upsample_2x2.sv
module tb_module_upsample_2x2;
   localparam int W    = 8;
   localparam int COLS = 4;
   localparam int ROWS = 2;

   typedef struct {
      logic [W-1:0] d;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   module_upsample_2x2_if #(.WIDTH(W)) bus ();

   module_upsample_2x2 #(.WIDTH(W), .COL_NUM(COLS), .ROW_NUM(ROWS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t exp_q[$];
   logic [W-1:0] model_row[$];
   int   model_row_idx = 0;
   int   beats_seen = 0;
   int   rdy_mode = 0;  // 0: always ready, 1: random, 2: pattern 1,0,0,1
   int   pidx = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: once a full row has been accepted, the output is that row with
   // every pixel doubled, repeated twice. The frame ends on the second copy of the last row.
   task automatic model_accept(input logic [W-1:0] v);
      exp_t e;
      model_row.push_back(v);
      if (model_row.size() == COLS) begin
         for (int rep = 0; rep < 2; rep++)
            for (int k = 0; k < 2 * COLS; k++) begin
               e.d    = model_row[k / 2];
               e.last = (rep == 1) && (k == 2 * COLS - 1) && (model_row_idx == ROWS - 1);
               exp_q.push_back(e);
            end
         model_row.delete();
         model_row_idx = (model_row_idx + 1) % ROWS;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_row.delete();
      model_row_idx = 0;
   endtask

   // out_ready driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: bus.out_ready = 1'($urandom_range(0, 1));
         2: begin
            bus.out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
            pidx++;
         end
         default: bus.out_ready = 1'b1;
      endcase
   end

   // Monitor: sample at the falling edge. A beat seen here completes on the next rising edge.
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_d;
   logic         prev_last;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else if (bus.out_valid) begin
         if (prev_stall) begin
            chk("stall_dout_stable", 32'(bus.dout), 32'(prev_d));
            chk("stall_last_stable", 32'(bus.out_last), 32'(prev_last));
         end
         if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(bus.dout), 32'hDEAD);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("dout", 32'(bus.dout), 32'(e.d));
               chk("out_last", 32'(bus.out_last), 32'(e.last));
            end
            beats_seen++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            prev_d     = bus.dout;
            prev_last  = bus.out_last;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send_pixel(input logic [W-1:0] v, input int gap);
      bit ok = 0;
      bus.in_valid = 1'b1;
      bus.din      = v;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.din      = 8'hxx;
      if (ok) model_accept(v);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
   endtask

   task automatic send_row(input logic [W-1:0] a, b, c, d, input int gap);
      send_pixel(a, gap); send_pixel(b, gap); send_pixel(c, gap); send_pixel(d, gap);
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && bus.in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cnt;
      int base;
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.out_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: basic row, latency and input blocking
      send_pixel(8'd1, 0); send_pixel(8'd2, 0); send_pixel(8'd3, 0); send_pixel(8'd4, 0);
      @(negedge clk);
      chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.in_ready) break;
         cnt++;
         @(negedge clk);
      end
      chk("in_ready_low_cycles", 32'(cnt), 32'd16);
      @(posedge clk); #1;

      // 2: second row completes the frame (signed extremes, last on beat 32)
      send_row(8'hFF, 8'h80, 8'h7F, 8'h00, 0);
      wait_drain();
      @(posedge clk); #1;

      // 3: out_ready pattern stalls (row counter wrapped, so this is row 0 again)
      rdy_mode = 2; pidx = 0;
      send_row(8'd1, 8'd2, 8'd3, 8'd4, 0);
      wait_drain();
      rdy_mode = 0;
      @(posedge clk); #1;

      // 4: input gaps, 1 valid beat in 3 cycles
      send_row(8'd5, 8'd6, 8'd7, 8'd8, 2);
      wait_drain();
      @(posedge clk); #1;

      // 5: reset after the 6th output beat of row 0
      base = beats_seen;
      send_row(8'd10, 8'd20, 8'd30, 8'd40, 0);
      for (int i = 0; i < 100; i++) begin
         if (beats_seen >= base + 6) break;
         @(negedge clk);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_last", 32'(bus.out_last), 32'd0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      send_row(8'd9, 8'd8, 8'd7, 8'd6, 0);
      wait_drain();
      @(posedge clk); #1;

      // 6: in_valid held with changing data while emitting
      send_row(8'd11, 8'd12, 8'd13, 8'd14, 0);
      bus.in_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         bus.din = W'($urandom);
         cnt++;
      end
      bus.in_valid = 1'b0;
      chk("emit_blocks_input", 32'(cnt), 32'd16);
      wait_drain();
      @(posedge clk); #1;

      // randomized rows, random backpressure and input gaps
      rdy_mode = 1;
      for (int r = 0; r < 8; r++)
         send_row(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                  int'($urandom_range(0, 2)));
      wait_drain();
      rdy_mode = 0;
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
